// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path: controller state encoding,
// the bit-period reload table indexed by baud select, and the length of the
// post-byte guard window.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GUARD = 2'd3
  } rx_state_t;

  // Cycles spent in GUARD after a byte, covering the stop-bit tail.
  localparam int GUARD_CYC = 32;

  // Terminal count of the bit-period counter (counter runs 0..N, so one bit
  // lasts N+1 clocks at 100 MHz).
  function automatic logic [13:0] baud_cnt(input logic [2:0] sel);
    logic [13:0] n;
    case (sel)
      3'd0:    n = 14'd10416;
      3'd1:    n = 14'd5208;
      3'd2:    n = 14'd2604;
      3'd3:    n = 14'd1736;
      3'd4:    n = 14'd868;
      3'd5:    n = 14'd434;
      3'd6:    n = 14'd217;
      default: n = 14'd108;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Show-ahead byte FIFO for received characters with sticky overrun flag.
// Ports:
//   clock, resetn      clock, synchronous active-low reset
//   push, wr_data      write strobe and byte (dropped when full and no pop)
//   pop                pop request (ignored while empty)
//   ovr_clr            clears ovr_flag (a same-cycle overrun wins)
//   rd_data            head byte, 0 while empty
//   level, empty, full registered occupancy status
//   ovr_flag           sticky overrun flag
//   push_acc, pop_acc  accepted push / pop this cycle
module uart_rx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  logic [7:0]    wr_data,
  input  logic          pop,
  input  logic          ovr_clr,
  output logic [7:0]    rd_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          ovr_flag,
  output logic          push_acc,
  output logic          pop_acc
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   level_reg, level_next;
  logic          empty_reg, full_reg, ovr_reg;

  assign pop_acc  = pop && !empty_reg;
  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign push_acc = push && (!full_reg || pop_acc);

  always_comb begin
    level_next = level_reg;
    if (push_acc && !pop_acc)
      level_next = level_reg + (AW+1)'(1);
    else if (pop_acc && !push_acc)
      level_next = level_reg - (AW+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (push_acc)
      mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
      ovr_reg    <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_acc)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
      empty_reg <= (level_next == '0);
      full_reg  <= (level_next == (AW+1)'(DEPTH));
      if (push && full_reg && !pop_acc)
        ovr_reg <= 1'b1;
      else if (ovr_clr)
        ovr_reg <= 1'b0;
    end
  end

  // Gate the head with empty so reset and drained states read as 0.
  assign rd_data  = empty_reg ? 8'h00 : mem[rd_ptr_reg];
  assign level    = level_reg;
  assign empty    = empty_reg;
  assign full     = full_reg;
  assign ovr_flag = ovr_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Controller for the uart_rx datapath: enables the receiver, applies baud
// select changes only between frames, tracks frame occupancy from the RX
// line, buffers bytes and raises threshold / timeout / overrun interrupts.
// Ports:
//   clock, resetn            clock, synchronous active-low reset
//   cfg_en, cfg_baud_sel     requested enable and baud select
//   cfg_thresh               IRQ level threshold (0 behaves as 1)
//   rx_line                  raw RX pin
//   uart_en, baud_rx_sel     control to uart_rx
//   rec_valid, rec_dat       byte strobe and data from uart_rx
//   rd_en, rd_data           FIFO pop and show-ahead head
//   fifo_level, empty, full  FIFO status
//   busy                     frame in progress (BUSY or GUARD)
//   ovr_flag, ovr_clr        sticky overrun flag and its clear
//   to_flag                  character timeout
//   irq                      combined interrupt
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter  int DEPTH    = 8,
  parameter  int TO_BITS  = 40,
  parameter  int WDG_BITS = 12,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cfg_en,
  input  logic [2:0]    cfg_baud_sel,
  input  logic [AW:0]   cfg_thresh,
  input  logic          rx_line,
  output logic          uart_en,
  output logic [2:0]    baud_rx_sel,
  input  logic          rec_valid,
  input  logic [7:0]    rec_dat,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic [AW:0]   fifo_level,
  output logic          empty,
  output logic          full,
  output logic          busy,
  output logic          ovr_flag,
  input  logic          ovr_clr,
  output logic          to_flag,
  output logic          irq
);

  localparam int WW = $clog2(WDG_BITS + 1);

  rx_state_t     state_reg, state_next;
  logic [2:0]    baud_sel_reg, baud_sel_next;
  logic          sync1_reg, sync2_reg;
  logic [13:0]   tick_cnt_reg;
  logic [WW-1:0] wdg_cnt_reg;
  logic [5:0]    to_cnt_reg;
  logic          to_flag_reg, uart_en_reg, busy_reg;
  logic          start_edge, bit_tick, state_chg;
  logic          push_acc, pop_acc;
  logic [AW:0]   thresh_eff;

  // Same falling-edge detector as uart_rx, so both see the start together.
  assign start_edge = !sync1_reg && sync2_reg;
  // >= rather than == so a select change in IDLE that shortens the period
  // while the counter is already past the new terminal still ticks at once.
  assign bit_tick   = (tick_cnt_reg >= baud_cnt(baud_sel_reg));
  assign state_chg  = (state_next != state_reg);

  always_comb begin
    state_next    = state_reg;
    baud_sel_next = baud_sel_reg;
    case (state_reg)
      ST_OFF: begin
        if (cfg_en) begin
          state_next    = ST_IDLE;
          baud_sel_next = cfg_baud_sel;
        end
      end
      ST_IDLE: begin
        if (!cfg_en)
          state_next = ST_OFF;
        else if (start_edge)
          state_next = ST_BUSY;           // a coincident select change waits
        else if (cfg_baud_sel != baud_sel_reg)
          baud_sel_next = cfg_baud_sel;
      end
      ST_BUSY: begin
        if (rec_valid)
          state_next = ST_GUARD;
        else if (bit_tick && wdg_cnt_reg == WW'(WDG_BITS - 1))
          state_next = ST_GUARD;          // frame abandoned by watchdog
      end
      ST_GUARD: begin
        // The tick counter restarts on GUARD entry and never reaches a bit
        // terminal within the guard window, so it doubles as the cycle count.
        if (tick_cnt_reg == 14'(GUARD_CYC - 1)) begin
          if (!cfg_en)
            state_next = ST_OFF;
          else begin
            state_next    = ST_IDLE;
            baud_sel_next = cfg_baud_sel;
          end
        end
      end
      default: state_next = ST_OFF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg    <= ST_OFF;
      baud_sel_reg <= 3'd0;
      sync1_reg    <= 1'b1;
      sync2_reg    <= 1'b1;
      tick_cnt_reg <= '0;
      wdg_cnt_reg  <= '0;
      to_cnt_reg   <= '0;
      to_flag_reg  <= 1'b0;
      uart_en_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_sel_reg <= baud_sel_next;
      sync1_reg    <= rx_line;
      sync2_reg    <= sync1_reg;
      uart_en_reg  <= (state_next != ST_OFF);
      busy_reg     <= (state_next == ST_BUSY) || (state_next == ST_GUARD);

      if (state_chg || bit_tick)
        tick_cnt_reg <= '0;
      else
        tick_cnt_reg <= tick_cnt_reg + 14'd1;

      if (state_chg)
        wdg_cnt_reg <= '0;
      else if (state_reg == ST_BUSY && bit_tick)
        wdg_cnt_reg <= wdg_cnt_reg + WW'(1);

      // Idle-character counter saturates at the timeout value.
      if (push_acc || pop_acc || empty)
        to_cnt_reg <= '0;
      else if (state_reg == ST_IDLE && bit_tick && to_cnt_reg != 6'(TO_BITS))
        to_cnt_reg <= to_cnt_reg + 6'd1;

      if (pop_acc || empty)
        to_flag_reg <= 1'b0;
      else if (to_cnt_reg == 6'(TO_BITS))
        to_flag_reg <= 1'b1;
    end
  end

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .resetn   (resetn),
    .push     (rec_valid),
    .wr_data  (rec_dat),
    .pop      (rd_en),
    .ovr_clr  (ovr_clr),
    .rd_data  (rd_data),
    .level    (fifo_level),
    .empty    (empty),
    .full     (full),
    .ovr_flag (ovr_flag),
    .push_acc (push_acc),
    .pop_acc  (pop_acc)
  );

  assign thresh_eff  = (cfg_thresh == '0) ? (AW+1)'(1) : cfg_thresh;
  assign irq         = (fifo_level >= thresh_eff) || to_flag_reg || ovr_flag;
  assign uart_en     = uart_en_reg;
  assign baud_rx_sel = baud_sel_reg;
  assign busy        = busy_reg;
  assign to_flag     = to_flag_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
// Directed self-checking bench for uart_rx_ctrl (DEPTH=8, TO_BITS=40,
// WDG_BITS=12). The uart_rx datapath is abstracted: the bench drives the RX
// line for start edges and pulses rec_valid itself.
module tb_uart_rx_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic       cfg_en;
  logic [2:0] cfg_baud_sel;
  logic [3:0] cfg_thresh;
  logic       rx_line;
  logic       uart_en;
  logic [2:0] baud_rx_sel;
  logic       rec_valid;
  logic [7:0] rec_dat;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [3:0] fifo_level;
  logic       empty, full, busy, ovr_flag, ovr_clr, to_flag, irq;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  uart_rx_ctrl dut (
    .clock        (clock),
    .resetn       (resetn),
    .cfg_en       (cfg_en),
    .cfg_baud_sel (cfg_baud_sel),
    .cfg_thresh   (cfg_thresh),
    .rx_line      (rx_line),
    .uart_en      (uart_en),
    .baud_rx_sel  (baud_rx_sel),
    .rec_valid    (rec_valid),
    .rec_dat      (rec_dat),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .fifo_level   (fifo_level),
    .empty        (empty),
    .full         (full),
    .busy         (busy),
    .ovr_flag     (ovr_flag),
    .ovr_clr      (ovr_clr),
    .to_flag      (to_flag),
    .irq          (irq)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) step();
    check("guard_exit", 16'(busy), 16'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_line = 1'b0;
    repeat (4) step();
    rx_line = 1'b1;
    repeat (2) step();
    rec_dat   = b;
    rec_valid = 1'b1;
    step();
    rec_valid = 1'b0;
    wait_idle();
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; cfg_en = 1'b0; cfg_baud_sel = 3'd0; cfg_thresh = 4'd8;
    rx_line = 1'b1; rec_valid = 1'b0; rec_dat = 8'h00; rd_en = 1'b0; ovr_clr = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    step();

    // Reset state
    check("rst_uart_en", 16'(uart_en), 16'd0);
    check("rst_baud",    16'(baud_rx_sel), 16'd0);
    check("rst_level",   16'(fifo_level), 16'd0);
    check("rst_empty",   16'(empty), 16'd1);
    check("rst_full",    16'(full), 16'd0);
    check("rst_busy",    16'(busy), 16'd0);
    check("rst_ovr",     16'(ovr_flag), 16'd0);
    check("rst_to",      16'(to_flag), 16'd0);
    check("rst_irq",     16'(irq), 16'd0);
    check("rst_rd_data", 16'(rd_data), 16'd0);

    // Enable at sel 4 and receive 0xA5, changing select mid-frame
    cfg_baud_sel = 3'd4; cfg_en = 1'b1;
    step();
    check("en_uart_en", 16'(uart_en), 16'd1);
    check("en_baud",    16'(baud_rx_sel), 16'd4);
    rx_line = 1'b0;
    step();
    check("busy_pre",   16'(busy), 16'd0);
    step();
    check("busy_rise",  16'(busy), 16'd1);
    cfg_baud_sel = 3'd7;
    repeat (3) step();
    check("baud_held",  16'(baud_rx_sel), 16'd4);
    rx_line = 1'b1;
    step();
    rec_dat = 8'hA5; rec_valid = 1'b1;
    step();
    rec_valid = 1'b0;
    check("a5_level",   16'(fifo_level), 16'd1);
    check("a5_empty",   16'(empty), 16'd0);
    check("a5_data",    16'(rd_data), 16'hA5);
    check("guard_busy", 16'(busy), 16'd1);
    repeat (31) step();
    check("guard_last", 16'(busy), 16'd1);
    check("guard_baud", 16'(baud_rx_sel), 16'd4);
    step();
    check("guard_done", 16'(busy), 16'd0);
    check("baud_new",   16'(baud_rx_sel), 16'd7);
    check("idle_en",    16'(uart_en), 16'd1);
    pop1();
    check("pop_empty",  16'(empty), 16'd1);
    check("pop_level",  16'(fifo_level), 16'd0);

    // Next frame at the new rate
    send_byte(8'h3C);
    check("sel7_data",  16'(rd_data), 16'h3C);
    check("sel7_level", 16'(fifo_level), 16'd1);
    pop1();

    // Overrun
    cfg_thresh = 4'd15;
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    check("ov_full",    16'(full), 16'd1);
    check("ov_level8",  16'(fifo_level), 16'd8);
    check("ov_pre",     16'(ovr_flag), 16'd0);
    check("ov_pre_irq", 16'(irq), 16'd0);
    send_byte(8'h99);
    check("ov_flag",    16'(ovr_flag), 16'd1);
    check("ov_irq",     16'(irq), 16'd1);
    check("ov_level",   16'(fifo_level), 16'd8);
    check("ov_head",    16'(rd_data), 16'h10);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ov_clr",     16'(ovr_flag), 16'd0);
    check("ov_clr_irq", 16'(irq), 16'd0);
    rec_dat = 8'hEE; rec_valid = 1'b1; rd_en = 1'b1;
    step();
    rec_valid = 1'b0; rd_en = 1'b0;
    check("pp_level",   16'(fifo_level), 16'd8);
    check("pp_full",    16'(full), 16'd1);
    check("pp_head",    16'(rd_data), 16'h11);
    check("pp_ovr",     16'(ovr_flag), 16'd0);
    rec_dat = 8'h77; rec_valid = 1'b1; ovr_clr = 1'b1;
    step();
    rec_valid = 1'b0; ovr_clr = 1'b0;
    check("set_wins",   16'(ovr_flag), 16'd1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("drain_data", 16'(rd_data), (i < 7) ? 16'h11 + 16'(i) : 16'hEE);
      pop1();
    end
    check("drain_empty", 16'(empty), 16'd1);
    pop1();
    check("pop_on_empty", 16'(fifo_level), 16'd0);

    // Threshold IRQ
    cfg_thresh = 4'd3;
    send_byte(8'h01);
    send_byte(8'h02);
    check("th_below",   16'(irq), 16'd0);
    send_byte(8'h03);
    check("th_reach",   16'(irq), 16'd1);
    pop1();
    check("th_pop",     16'(irq), 16'd0);
    pop1();
    pop1();
    cfg_thresh = 4'd0;
    step();
    check("th0_empty",  16'(irq), 16'd0);
    send_byte(8'h44);
    check("th0_one",    16'(irq), 16'd1);

    // Character timeout with the byte left unread
    cfg_thresh = 4'd15;
    step();
    check("to_irq_off", 16'(irq), 16'd0);
    repeat (39 * 109) step();
    check("to_early",   16'(to_flag), 16'd0);
    for (int i = 0; i < 300 && !to_flag; i++) step();
    check("to_set",     16'(to_flag), 16'd1);
    check("to_irq",     16'(irq), 16'd1);
    pop1();
    check("to_clr",     16'(to_flag), 16'd0);
    check("to_clr_irq", 16'(irq), 16'd0);

    // Graceful disable mid-frame
    rx_line = 1'b0;
    repeat (3) step();
    cfg_en = 1'b0;
    repeat (2) step();
    check("dis_en_busy", 16'(uart_en), 16'd1);
    check("dis_busy",    16'(busy), 16'd1);
    rx_line = 1'b1;
    step();
    rec_dat = 8'h5A; rec_valid = 1'b1;
    step();
    rec_valid = 1'b0;
    check("dis_level",   16'(fifo_level), 16'd1);
    check("dis_en_grd",  16'(uart_en), 16'd1);
    wait_idle();
    check("dis_off",     16'(uart_en), 16'd0);
    check("dis_data",    16'(rd_data), 16'h5A);
    pop1();
    cfg_en = 1'b1;
    step();
    check("reen",        16'(uart_en), 16'd1);
    check("reen_baud",   16'(baud_rx_sel), 16'd7);

    // Watchdog: line held low with no byte
    rx_line = 1'b0;
    repeat (2) step();
    repeat (1200) step();
    check("wdg_hold",    16'(busy), 16'd1);
    for (int i = 0; i < 300 && busy; i++) step();
    check("wdg_exit",    16'(busy), 16'd0);
    check("wdg_level",   16'(fifo_level), 16'd0);
    check("wdg_empty",   16'(empty), 16'd1);
    rx_line = 1'b1;
    repeat (3) step();
    check("wdg_quiet",   16'(busy), 16'd0);
    check("wdg_en",      16'(uart_en), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
